// File: rtl/right_shift_pipe_pkg.sv
// Shared definitions for the pipelined right shifter.
// Provides the width-to-stage-count helper and the default geometry.
package right_shift_pipe_pkg;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    localparam int DEFAULT_STAGES = clog2(DEFAULT_WIDTH);

endpackage

// File: rtl/right_shift_stage.sv
// One registered log-stage of the right shifter.
// When selected, it shifts right by a fixed amount and fills the vacated MSBs.
module right_shift_stage
    import right_shift_pipe_pkg::*;
#(
    parameter int width = DEFAULT_WIDTH,
    parameter int amt   = 1,
    parameter int rem_w = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_ready,
    input  logic             i_valid,
    input  logic [width-1:0] i_data,
    input  logic             i_fill,
    input  logic             i_sel,
    input  logic [rem_w-1:0] i_rem,
    output logic             o_valid,
    output logic [width-1:0] o_data,
    output logic             o_fill,
    output logic [rem_w-1:0] o_rem
);

    logic             r_valid;
    logic [width-1:0] r_data;
    logic             r_fill;
    logic [rem_w-1:0] r_rem;
    logic [width-1:0] w_shifted;

    assign w_shifted = i_sel ? {{amt{i_fill}}, i_data[width-1:amt]} : i_data;

    // NOTE: non-blocking assignments so every stage samples its upstream's pre-edge value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: data is cleared as well as valid so oBits reads 0 after reset.
            r_valid <= 1'b0;
            r_data  <= '0;
            r_fill  <= 1'b0;
            r_rem   <= '0;
        end else if (i_ready) begin
            r_valid <= i_valid;
            r_data  <= w_shifted;
            r_fill  <= i_fill;
            r_rem   <= i_rem;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_fill  = r_fill;
    assign o_rem   = r_rem;

endmodule

// File: rtl/right_shift_pipe.sv
// Pipelined logical/arithmetic right shifter, one stage per shift bit,
// with valid/ready handshakes on the producer and consumer sides.
module right_shift_pipe
    import right_shift_pipe_pkg::*;
#(
    parameter int width = DEFAULT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [width-1:0]        iBits,
    input  logic [clog2(width)-1:0] shift,
    input  logic                    arith,
    input  logic                    iValid,
    output logic                    iReady,
    output logic [width-1:0]        oBits,
    output logic                    oValid,
    input  logic                    oReady
);

    localparam int STAGES = clog2(width);

    // Index 0 is the input side; index k+1 is the output of stage k.
    logic [width-1:0]  w_data [0:STAGES];
    logic [STAGES-1:0] w_rem  [0:STAGES];
    logic              w_fill [0:STAGES];
    logic [STAGES:0]   w_valid;
    logic [STAGES-1:0] w_ready;

    assign w_data[0]  = iBits;
    assign w_rem[0]   = shift;
    assign w_fill[0]  = arith & iBits[width-1];
    assign w_valid[0] = iValid;

    // Stage k may load when it is empty or everything downstream can move.
    always_comb begin : ready_chain
        logic w_down;
        w_down = oReady;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_down     = w_down | ~w_valid[k+1];
            w_ready[k] = w_down;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        right_shift_stage #(
            .width (width),
            .amt   (1 << k),
            .rem_w (STAGES)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_ready (w_ready[k]),
            .i_valid (w_valid[k]),
            .i_data  (w_data[k]),
            .i_fill  (w_fill[k]),
            .i_sel   (w_rem[k][0]),
            .i_rem   (w_rem[k] >> 1),
            .o_valid (w_valid[k+1]),
            .o_data  (w_data[k+1]),
            .o_fill  (w_fill[k+1]),
            .o_rem   (w_rem[k+1])
        );
    end

    assign iReady = w_ready[0];
    assign oBits  = w_data[STAGES];
    assign oValid = w_valid[STAGES];

endmodule

// File: tb/tb_right_shift_pipe.sv
// Self-checking bench for right_shift_pipe (width 8 and width 6 instances)
// against a queue-based reference model of the shift rules.
module tb_right_shift_pipe;

    logic       clk = 1'b0;
    logic       rst_n;

    logic [7:0] iBits;
    logic [2:0] shift;
    logic       arith;
    logic       iValid;
    logic       iReady;
    logic [7:0] oBits;
    logic       oValid;
    logic       oReady;

    logic [5:0] b_iBits;
    logic [2:0] b_shift;
    logic       b_arith;
    logic       b_iValid;
    logic       b_iReady;
    logic [5:0] b_oBits;
    logic       b_oValid;
    logic       b_oReady;

    int          total = 0;
    int          bad   = 0;
    int          out_cnt = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    right_shift_pipe #(.width(8)) u_dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .iBits  (iBits),
        .shift  (shift),
        .arith  (arith),
        .iValid (iValid),
        .iReady (iReady),
        .oBits  (oBits),
        .oValid (oValid),
        .oReady (oReady)
    );

    right_shift_pipe #(.width(6)) u_dut6 (
        .clk    (clk),
        .rst_n  (rst_n),
        .iBits  (b_iBits),
        .shift  (b_shift),
        .arith  (b_arith),
        .iValid (b_iValid),
        .iReady (b_iReady),
        .oBits  (b_oBits),
        .oValid (b_oValid),
        .oReady (b_oReady)
    );

    // Arithmetic right shift expressed as a logical shift of the complement.
    function automatic logic [31:0] ref_shift(logic [31:0] x, int s, logic a, int w);
        logic [31:0] mask;
        logic [31:0] xm;
        mask = (32'd1 << w) - 32'd1;
        xm   = x & mask;
        if (a && xm[w-1])
            return ~((~xm & mask) >> s) & mask;
        return xm >> s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Records transfers on the 8-bit instance, then advances one clock.
    task automatic tick();
        #1;
        if (iValid && iReady)
            exp_q.push_back(ref_shift({24'd0, iBits}, int'(shift), arith, 8));
        if (oValid && oReady) begin
            out_cnt++;
            if (exp_q.size() == 0)
                check("spurious_out", {31'd0, oValid}, 32'd0);
            else
                check("out_data", {24'd0, oBits}, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic single_beat(input logic [7:0] bits, input logic [2:0] sh,
                               input logic ar, input logic [7:0] want, input string tag);
        int n;
        iBits  = bits;
        shift  = sh;
        arith  = ar;
        iValid = 1'b1;
        oReady = 1'b1;
        #1;
        check({tag, "_iready"}, {31'd0, iReady}, 32'd1);
        tick();
        iValid = 1'b0;
        n = 1;
        while (!oValid && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 32'd3);
        check({tag, "_data"}, {24'd0, oBits}, {24'd0, want});
        tick();
    endtask

    task automatic b_beat(input logic ar, input logic [5:0] want, input string tag);
        int n;
        b_iBits  = 6'b100000;
        b_shift  = 3'd7;
        b_arith  = ar;
        b_iValid = 1'b1;
        b_oReady = 1'b1;
        #1;
        check({tag, "_iready"}, {31'd0, b_iReady}, 32'd1);
        @(posedge clk);
        #1;
        b_iValid = 1'b0;
        n = 1;
        while (!b_oValid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, n, 32'd3);
        check({tag, "_data"}, {26'd0, b_oBits}, {26'd0, want});
        check({tag, "_model"}, {26'd0, b_oBits}, ref_shift(32'h20, 7, ar, 6));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        ov [0:24];
        int          first, last, ones, idx, n, out_base;
        logic        accepted, have_ref, prev_stall;
        logic [7:0]  ref_bits, prev_bits;

        rst_n    = 1'b0;
        iBits    = '0; shift = '0; arith = 1'b0; iValid = 1'b0; oReady = 1'b0;
        b_iBits  = '0; b_shift = '0; b_arith = 1'b0; b_iValid = 1'b0; b_oReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ovalid", {31'd0, oValid}, 32'd0);
        check("rst_obits", {24'd0, oBits}, 32'd0);
        check("rst_iready", {31'd0, iReady}, 32'd1);
        rst_n = 1'b1;

        // Directed vectors: logical and arithmetic fills.
        single_beat(8'hB4, 3'd2, 1'b0, 8'h2D, "lsr_b4");
        single_beat(8'hB4, 3'd2, 1'b1, 8'hED, "asr_b4");
        single_beat(8'h34, 3'd2, 1'b1, 8'h0D, "asr_34");
        single_beat(8'h80, 3'd7, 1'b1, 8'hFF, "asr_max");
        single_beat(8'h5A, 3'd0, 1'b1, 8'h5A, "shift0");

        // Streaming: 16 back-to-back beats with the consumer always ready.
        oReady = 1'b1;
        for (int c = 0; c < 25; c++) begin
            if (c < 16) begin
                iBits  = 8'(c);
                shift  = 3'(c % 8);
                arith  = 1'(c & 1);
                iValid = 1'b1;
            end else begin
                iValid = 1'b0;
            end
            #1;
            if (c < 16)
                check("stream_iready", {31'd0, iReady}, 32'd1);
            ov[c] = oValid;
            tick();
        end
        first = -1; last = -1; ones = 0;
        for (int c = 0; c < 25; c++) begin
            if (ov[c]) begin
                ones++;
                if (first < 0) first = c;
                last = c;
            end
        end
        check("stream_count", ones, 32'd16);
        check("stream_contig", last - first + 1, 32'd16);
        check("stream_first", first, 32'd3);
        check("stream_empty", exp_q.size(), 32'd0);

        // Back-pressure: consumer stalled for 6 cycles, producer holds until accepted.
        oReady   = 1'b0;
        idx      = 0;
        have_ref = 1'b0;
        ref_bits = '0;
        out_base = out_cnt;
        for (int c = 0; c < 6; c++) begin
            iBits  = 8'(8'hC1 + idx * 37);
            shift  = 3'(idx + 1);
            arith  = 1'b1;
            iValid = 1'b1;
            #1;
            accepted = iValid && iReady;
            if (oValid) begin
                if (!have_ref) begin
                    ref_bits = oBits;
                    have_ref = 1'b1;
                    check("bp_head", {24'd0, oBits}, exp_q[0]);
                end else begin
                    check("bp_stable", {24'd0, oBits}, {24'd0, ref_bits});
                end
            end
            tick();
            if (accepted) idx++;
        end
        check("bp_accepted", idx, 32'd3);
        check("bp_iready_low", {31'd0, iReady}, 32'd0);
        check("bp_ovalid", {31'd0, oValid}, 32'd1);
        iValid = 1'b0;
        oReady = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            tick();
            n++;
        end
        check("bp_drained", exp_q.size(), 32'd0);
        check("bp_out_count", out_cnt - out_base, 32'd3);

        // Randomized traffic with random consumer stalls.
        prev_stall = 1'b0;
        prev_bits  = '0;
        for (int c = 0; c < 200; c++) begin
            iValid = 1'($urandom_range(0, 1));
            iBits  = 8'($urandom);
            shift  = 3'($urandom_range(0, 7));
            arith  = 1'($urandom_range(0, 1));
            oReady = ($urandom_range(0, 3) != 0);
            #1;
            if (prev_stall) begin
                check("rnd_hold_valid", {31'd0, oValid}, 32'd1);
                check("rnd_hold_bits", {24'd0, oBits}, {24'd0, prev_bits});
            end
            prev_stall = oValid && !oReady;
            prev_bits  = oBits;
            tick();
        end
        iValid = 1'b0;
        oReady = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            tick();
            n++;
        end
        check("rnd_drained", exp_q.size(), 32'd0);

        // Reset with three beats in flight.
        oReady = 1'b1;
        for (int c = 0; c < 3; c++) begin
            iBits  = 8'(8'h90 + c);
            shift  = 3'(c);
            arith  = 1'b0;
            iValid = 1'b1;
            tick();
        end
        iValid = 1'b0;
        oReady = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        check("midrst_ovalid", {31'd0, oValid}, 32'd0);
        check("midrst_obits", {24'd0, oBits}, 32'd0);
        check("midrst_iready", {31'd0, iReady}, 32'd1);
        single_beat(8'h81, 3'd1, 1'b1, 8'hC0, "post_rst");

        // Non-power-of-two width: shift amount beyond width gives all fill bits.
        b_beat(1'b0, 6'b000000, "w6_lsr7");
        b_beat(1'b1, 6'b111111, "w6_asr7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
